// File: rtl/oled_pkg.sv
// Shared types and the fixed SSD1306 power-on command list for the OLED frame streamer.
package oled_pkg;

    typedef enum logic [2:0] {
        StRstHi,
        StRstLo,
        StRstRel,
        StLoadCmd,
        StSend,
        StCheck,
        StLoadData
    } state_e;

    localparam int unsigned INIT_LEN = 16;
    localparam logic [3:0]  LAST_CMD = 4'(INIT_LEN - 1);

    // Display off, clock, mux 64, contrast, normal, horizontal addressing,
    // remaps, charge pump on, display on.
    localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'h81, 8'h7F, 8'hA6,
        8'h20, 8'h00, 8'hC8, 8'h40, 8'hA1, 8'h8D, 8'h14, 8'hAF
    };

    function automatic logic [7:0] init_cmd(input logic [3:0] idx);
        return INIT_CMDS[idx];
    endfunction

endpackage

// File: rtl/oled_frame_streamer_if.sv
// Panel pins plus the pixel fetch bus between the streamer and the text engine.
interface oled_frame_streamer_if;

    logic [9:0] pixelAddress;
    logic [7:0] pixelData;
    logic       io_sclk;
    logic       io_sdin;
    logic       io_cs;
    logic       io_dc;
    logic       io_reset;
    logic       frame_done;

    modport master (
        output pixelAddress,
        input  pixelData,
        output io_sclk,
        output io_sdin,
        output io_cs,
        output io_dc,
        output io_reset,
        output frame_done
    );

    modport slave (
        input  pixelAddress,
        output pixelData,
        input  io_sclk,
        input  io_sdin,
        input  io_cs,
        input  io_dc,
        input  io_reset,
        input  frame_done
    );

endinterface

// File: rtl/spi_byte_tx.sv
// Mode-3 style byte shifter: two clk per bit, MSB first, sclk idles high.
module spi_byte_tx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] din,
    output logic       sclk,
    output logic       sdin,
    output logic       busy,
    output logic       done
);

    logic [7:0] sr_q;
    logic [2:0] bit_cnt_q;
    logic       phase_q;
    logic       busy_q;
    logic       sclk_q;
    logic       sdin_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q      <= 8'h00;
            bit_cnt_q <= 3'd0;
            phase_q   <= 1'b0;
            busy_q    <= 1'b0;
            sclk_q    <= 1'b1;
            sdin_q    <= 1'b0;
        end else if (load) begin
            sr_q      <= din;
            bit_cnt_q <= 3'd0;
            phase_q   <= 1'b0;
            busy_q    <= 1'b1;
        end else if (busy_q) begin
            if (!phase_q) begin
                // Data goes out with the falling edge, a full clk ahead of the sampling edge.
                sclk_q  <= 1'b0;
                sdin_q  <= sr_q[7];
                phase_q <= 1'b1;
            end else begin
                sclk_q    <= 1'b1;
                sr_q      <= {sr_q[6:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                phase_q   <= 1'b0;
                if (bit_cnt_q == 3'd7) begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

    // High during the final rising-edge clk so the caller can advance without a bubble.
    assign done = busy_q & phase_q & (bit_cnt_q == 3'd7);
    assign busy = busy_q;
    assign sclk = sclk_q;
    assign sdin = sdin_q;

endmodule

// File: rtl/oled_frame_streamer.sv
// SSD1306 driver: panel reset, fixed init list, then an endless 1024-byte frame stream.
module oled_frame_streamer
    import oled_pkg::*;
#(
    parameter logic [31:0] STARTUP_WAIT = 32'd10_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    oled_frame_streamer_if.master  bus
);

    state_e      state_q, state_d;
    logic [31:0] wait_q, wait_d;
    logic [3:0]  cmd_idx_q, cmd_idx_d;
    logic        data_mode_q, data_mode_d;
    logic        ld_phase_q, ld_phase_d;
    logic [9:0]  addr_q, addr_d;
    logic        frame_done_q, frame_done_d;
    logic        dc_q, dc_d;
    logic        cs_q, cs_d;
    logic        panel_rst_q, panel_rst_d;

    logic        tx_load;
    logic [7:0]  tx_din;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_sclk;
    logic        tx_sdin;

    spi_byte_tx u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tx_load),
        .din   (tx_din),
        .sclk  (tx_sclk),
        .sdin  (tx_sdin),
        .busy  (tx_busy),
        .done  (tx_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRstHi;
            wait_q       <= 32'd0;
            cmd_idx_q    <= 4'd0;
            data_mode_q  <= 1'b0;
            ld_phase_q   <= 1'b0;
            addr_q       <= 10'd0;
            frame_done_q <= 1'b0;
            dc_q         <= 1'b0;
            cs_q         <= 1'b1;
            panel_rst_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            cmd_idx_q    <= cmd_idx_d;
            data_mode_q  <= data_mode_d;
            ld_phase_q   <= ld_phase_d;
            addr_q       <= addr_d;
            frame_done_q <= frame_done_d;
            dc_q         <= dc_d;
            cs_q         <= cs_d;
            panel_rst_q  <= panel_rst_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        cmd_idx_d    = cmd_idx_q;
        data_mode_d  = data_mode_q;
        ld_phase_d   = ld_phase_q;
        addr_d       = addr_q;
        frame_done_d = 1'b0;
        dc_d         = dc_q;
        cs_d         = cs_q;
        tx_load      = 1'b0;
        tx_din       = init_cmd(cmd_idx_q);

        case (state_q)
            StRstHi, StRstLo, StRstRel: begin
                if (wait_q == STARTUP_WAIT - 32'd1) begin
                    wait_d = 32'd0;
                    case (state_q)
                        StRstHi: state_d = StRstLo;
                        StRstLo: state_d = StRstRel;
                        default: state_d = StLoadCmd;
                    endcase
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            StLoadCmd: begin
                if (!tx_busy) begin
                    tx_load = 1'b1;
                    tx_din  = init_cmd(cmd_idx_q);
                    dc_d    = 1'b0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (tx_done) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (data_mode_q) begin
                    addr_d       = addr_q + 10'd1;
                    frame_done_d = (addr_q == 10'd1023);
                    ld_phase_d   = 1'b0;
                    state_d      = StLoadData;
                end else if (cmd_idx_q == LAST_CMD) begin
                    data_mode_d = 1'b1;
                    addr_d      = 10'd0;
                    ld_phase_d  = 1'b0;
                    state_d     = StLoadData;
                end else begin
                    cmd_idx_d = cmd_idx_q + 4'd1;
                    state_d   = StLoadCmd;
                end
            end
            StLoadData: begin
                // The text engine registers its output, so the byte only lines up a clk later.
                if (!ld_phase_q) begin
                    ld_phase_d = 1'b1;
                end else if (!tx_busy) begin
                    tx_load = 1'b1;
                    tx_din  = bus.pixelData;
                    dc_d    = 1'b1;
                    state_d = StSend;
                end
            end
            default: state_d = StRstHi;
        endcase

        if (state_d == StLoadCmd) begin
            cs_d = 1'b0;
        end
        panel_rst_d = (state_d != StRstLo);
    end

    assign bus.pixelAddress = addr_q;
    assign bus.io_sclk      = tx_sclk;
    assign bus.io_sdin      = tx_sdin;
    assign bus.io_cs        = cs_q;
    assign bus.io_dc        = dc_q;
    assign bus.io_reset     = panel_rst_q;
    assign bus.frame_done   = frame_done_q;

endmodule

// File: doc/oled_frame_streamer.md
# oled_frame_streamer

Sequential SPI master that drives the 128x64 SSD1306 OLED. It sits directly downstream of the text engine. After power-up it resets the panel and sends a fixed initialisation command list. It then streams the 1024-byte frame forever: it issues `pixelAddress`, takes the registered `pixelData` byte back, and shifts that byte out MSB-first with D/C high.

## Interface
- `STARTUP_WAIT`, default 32'd10_000_000: clk cycles held in each of the three panel-reset phases.
- `clk` input 1: system clock. The only clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `pixelAddress` output 10: frame byte index. `[9:7]` is the page (8 rows), `[6:0]` is the column. Feeds the text engine.
- `pixelData` input 8: font byte for `pixelAddress`. It is valid one clk after the address changes (the source is registered).
- `io_sclk` output 1: SPI clock. Idles high.
- `io_sdin` output 1: SPI data, MSB first.
- `io_cs` output 1: chip select, active-low.
- `io_dc` output 1: 0 means command byte, 1 means data byte.
- `io_reset` output 1: panel reset, active-low.
- `frame_done` output 1: one-clk pulse after the last byte (address 1023) has been shifted.

## Operation
- Reset values: `io_sclk`=1, `io_sdin`=0, `io_cs`=1, `io_dc`=0, `io_reset`=1, `pixelAddress`=0, `frame_done`=0. State is `RST_HI`, wait counter 0, command index 0, shift register 0, bit counter 0.
- States:
  - `RST_HI`: `io_reset`=1 for STARTUP_WAIT cycles, then go to `RST_LO`.
  - `RST_LO`: `io_reset`=0 for STARTUP_WAIT cycles, then go to `RST_REL`.
  - `RST_REL`: `io_reset`=1 for STARTUP_WAIT cycles, then go to `LOAD_CMD`.
  - `LOAD_CMD`: shift register ← `INIT_CMDS[cmd_idx]`, `io_dc`=0, `io_cs`=0, bit counter=0. Next state is `SEND`.
  - `SEND`: two clks per bit.
    - Phase 0: `io_sclk`=0, `io_sdin`=shift register[7].
    - Phase 1: `io_sclk`=1, shift register shifts left, bit counter increments.
    - After the 8th phase 1, go to `CHECK`.
  - `CHECK`, init mode:
    - If `cmd_idx` = INIT_LEN-1: enter data mode, `pixelAddress`=0, go to `LOAD_DATA`.
    - Otherwise `cmd_idx`+1, go to `LOAD_CMD`.
  - `CHECK`, data mode:
    - `pixelAddress`+1, wrapping 1023→0.
    - On wrap, pulse `frame_done` for exactly that cycle.
    - Go to `LOAD_DATA`.
  - `LOAD_DATA`: two cycles. `pixelAddress` is held stable for both.
    - Cycle 0: wait for the registered source.
    - Cycle 1: shift register ← `pixelData`, `io_dc`=1, bit counter=0.
    - Next state is `SEND`.
- `io_cs` stays 0 from the first `LOAD_CMD` until reset. It never de-asserts between bytes.
- `io_dc` changes only in `LOAD_CMD` and `LOAD_DATA`, so it is stable for the whole byte.
- Once data mode is entered, init never repeats without `rst_n`.
- Asserting `rst_n` mid-byte or mid-frame aborts immediately:
  - All outputs return to their reset values.
  - The panel reset sequence runs again in full.
  - No partial byte is completed.
- Widths:
  - Wait counter is 32 bits. The comparison is `== STARTUP_WAIT-1`.
  - `cmd_idx` is 4 bits for INIT_LEN=16.
  - `pixelAddress` wraps by natural 10-bit overflow.

## Timing
- Panel reset takes 3×STARTUP_WAIT cycles.
- Command byte: 1 (`LOAD_CMD`) + 16 (`SEND`) + 1 (`CHECK`) = 18 clks.
- Data byte: 2 (`LOAD_DATA`) + 16 + 1 = 19 clks.
- Init list: 16×18 = 288 clks. Steady-state frame: 1024×19 = 19456 clks.
- The panel samples `io_sdin` on the rising `io_sclk` edge. Data is set up one full clk before that edge.
- Distance between consecutive `frame_done` pulses is exactly 19456 clks.

## Structure
- Package `oled_pkg` holds:
  - The state enum.
  - `INIT_LEN`=16.
  - `INIT_CMDS`, in order: AE, D5, 80, A8, 3F, 81, 7F, A6, 20, 00, C8, 40, A1, 8D, 14, AF.
- One sub-module, `spi_byte_tx`. It contains the 8-bit shift register, bit counter and `io_sclk`/`io_sdin` generation, with `load`/`busy`/`done` handshakes.
- The top FSM owns the reset phases, the command/data sequencing and `pixelAddress`.

## Test plan
- Reset release with STARTUP_WAIT=4:
  - `io_reset` is 1 for 4 clks, 0 for 4 clks, then 1.
  - `io_cs` falls on clk 12.
  - `io_dc`=0 for the first 16 bytes.
- Init byte capture: decode MOSI on `io_sclk` rising edges. The 16 bytes equal `INIT_CMDS` exactly, each 18 clks apart.
- Data path: model a registered source returning `pixelData`=`pixelAddress[7:0]`^8'h5A. Decoded data bytes 0..1023 match the model, with `io_dc`=1.
- Wrap: after address 1023, `frame_done` pulses once for 1 clk. The next byte fetched is address 0 and no init bytes are resent. The pulse period is 19456.
- Mid-byte reset: drop `rst_n` during bit 3 of a data byte. All outputs take reset values asynchronously, and on release the full reset-plus-init sequence replays.
- Latency guard: the source changes `pixelData` only one clk after the address. The latched byte is always the one for the current address, never the previous one.
